// File: rtl/div_host_bridge.sv
// Host bridge for the byte-serial divider: serialises two 32-bit operands as eight
// push strobes, then deserialises the eight-byte result burst. Optional WAIT timeout: DIV_HOST_BRIDGE_TIMEOUT_EN.
module div_host_bridge #(
    parameter int GAP_CYCLES     = 1,
    parameter int TIMEOUT_CYCLES = 255
) (
    input  logic        clk,
    input  logic        rst,
    input  logic        req_valid,
    output logic        req_ready,
    input  logic        req_sign,
    input  logic [31:0] req_dividend,
    input  logic [31:0] req_divisor,
    output logic        div_push,
    output logic [7:0]  div_data,
    output logic        div_sign,
    output logic        div_select,
    input  logic        div_pull,
    input  logic [7:0]  div_dout,
    output logic        rsp_valid,
    input  logic        rsp_ready,
    output logic [31:0] rsp_quotient,
    output logic [31:0] rsp_remainder,
    output logic        rsp_timeout
);
    typedef enum logic [2:0] {S_IDLE, S_SEND, S_WAIT, S_RECV, S_DONE} state_t;

    localparam logic [3:0] GAP_LAST = 4'(GAP_CYCLES);

    if (GAP_CYCLES < 1 || GAP_CYCLES > 15 || TIMEOUT_CYCLES < 1 || TIMEOUT_CYCLES > 65535) begin : g_param_check
        $error("div_host_bridge: parameter out of range");
    end

    state_t      state, state_nxt;
    logic [63:0] sr;        // operands shift out MSB-first, results shift in from the top
    logic [2:0]  byte_cnt;
    logic [3:0]  gap_cnt;
    logic        sign_q;
    logic        expire;

`ifdef DIV_HOST_BRIDGE_TIMEOUT_EN
    localparam logic [15:0] TO_LAST = 16'(TIMEOUT_CYCLES - 1);
    logic [15:0] to_cnt;
    logic        to_flag;

    // A div_pull in the expiry cycle takes priority over the timeout.
    assign expire = (state == S_WAIT) && !div_pull && (to_cnt == TO_LAST);

    always_ff @(posedge clk) begin
        if (rst) begin
            to_cnt  <= '0;
            to_flag <= 1'b0;
        end else begin
            to_cnt <= (state == S_WAIT) ? to_cnt + 16'd1 : '0;
            if (expire)
                to_flag <= 1'b1;
            else if (state == S_IDLE)
                to_flag <= 1'b0;
        end
    end

    assign rsp_timeout = (state == S_DONE) && to_flag;
`else
    assign expire      = 1'b0;
    assign rsp_timeout = 1'b0;
`endif

    always_ff @(posedge clk) begin
        if (rst)
            state <= S_IDLE;
        else
            state <= state_nxt;
    end

    always_comb begin
        // NOTE: every output of this block gets a default first so no latch is inferred.
        state_nxt = state;
        req_ready = 1'b0;
        div_push  = 1'b0;
        rsp_valid = 1'b0;
        case (state)
            S_IDLE: begin
                req_ready = !rst;
                if (req_valid)
                    state_nxt = S_SEND;
            end
            S_SEND: begin
                div_push = (gap_cnt == GAP_LAST);
                if (div_push && byte_cnt == 3'd7)
                    state_nxt = S_WAIT;
            end
            S_WAIT: begin
                if (div_pull)
                    state_nxt = S_RECV;
                else if (expire)
                    state_nxt = S_DONE;
            end
            S_RECV: begin
                if (byte_cnt == 3'd7)
                    state_nxt = S_DONE;
            end
            S_DONE: begin
                rsp_valid = 1'b1;
                if (rsp_ready)
                    state_nxt = S_IDLE;
            end
            default: state_nxt = S_IDLE;
        endcase
    end

    // NOTE: sequential state uses non-blocking assignments so every register samples pre-edge values.
    always_ff @(posedge clk) begin
        if (rst) begin
            sr       <= '0;
            byte_cnt <= '0;
            gap_cnt  <= '0;
            sign_q   <= 1'b0;
        end else begin
            case (state)
                S_IDLE: begin
                    if (req_valid) begin
                        sr       <= {req_dividend, req_divisor};
                        sign_q   <= req_sign;
                        byte_cnt <= '0;
                        gap_cnt  <= '0;
                    end
                end
                S_SEND: begin
                    if (div_push) begin
                        sr       <= {sr[55:0], 8'h00};
                        byte_cnt <= byte_cnt + 3'd1;
                        gap_cnt  <= '0;
                    end else begin
                        gap_cnt <= gap_cnt + 4'd1;
                    end
                end
                S_WAIT: begin
                    if (div_pull) begin
                        sr       <= {div_dout, sr[63:8]};
                        byte_cnt <= 3'd1;
                    end else if (expire) begin
                        sr <= '0;
                    end
                end
                S_RECV: begin
                    sr       <= {div_dout, sr[63:8]};
                    byte_cnt <= byte_cnt + 3'd1;
                end
                default: ;
            endcase
        end
    end

    assign div_data      = (state == S_SEND) ? sr[63:56] : 8'h00;
    assign div_sign      = sign_q && (state == S_SEND || state == S_WAIT || state == S_RECV);
    assign div_select    = 1'b0;
    assign rsp_quotient  = (state == S_DONE) ? sr[63:32] : 32'h0;
    assign rsp_remainder = (state == S_DONE) ? sr[31:0]  : 32'h0;
endmodule

// File: tb/tb_div_host_bridge.sv
// Self-checking bench for div_host_bridge: a byte-level divider model answers the pushes,
// a scoreboard holds expected pushed bytes and responses.
module tb_div_host_bridge;
    localparam int GAP = 1;
    localparam int TO  = 10;

    logic        clk = 1'b0;
    logic        rst = 1'b1;
    logic        req_valid = 1'b0;
    logic        req_ready;
    logic        req_sign = 1'b0;
    logic [31:0] req_dividend = '0;
    logic [31:0] req_divisor = '0;
    logic        div_push;
    logic [7:0]  div_data;
    logic        div_sign;
    logic        div_select;
    logic        div_pull = 1'b0;
    logic [7:0]  div_dout = '0;
    logic        rsp_valid;
    logic        rsp_ready = 1'b0;
    logic [31:0] rsp_quotient;
    logic [31:0] rsp_remainder;
    logic        rsp_timeout;

    typedef struct packed {
        logic [31:0] q;
        logic [31:0] r;
        logic        to;
    } rsp_t;

    rsp_t       exp_q[$];
    logic [7:0] byte_q[$];
    int         n_tests = 0;
    int         n_fail  = 0;

    div_host_bridge #(.GAP_CYCLES(GAP), .TIMEOUT_CYCLES(TO)) dut (
        .clk(clk), .rst(rst),
        .req_valid(req_valid), .req_ready(req_ready), .req_sign(req_sign),
        .req_dividend(req_dividend), .req_divisor(req_divisor),
        .div_push(div_push), .div_data(div_data), .div_sign(div_sign), .div_select(div_select),
        .div_pull(div_pull), .div_dout(div_dout),
        .rsp_valid(rsp_valid), .rsp_ready(rsp_ready),
        .rsp_quotient(rsp_quotient), .rsp_remainder(rsp_remainder), .rsp_timeout(rsp_timeout)
    );

    always #5 clk = ~clk;

    initial begin
        #2_000_000;
        $display("FAIL watchdog: simulation did not finish, tests=%0d", n_tests);
        $fatal(1, "watchdog");
    end

    task automatic check(input string tag, input logic [63:0] got, input logic [63:0] exp);
        n_tests++;
        if (got !== exp) begin
            n_fail++;
            $display("FAIL %s: got 0x%0h, expected 0x%0h", tag, got, exp);
        end
    endtask

    // Divider behaviour: sign-magnitude when sgn=1; divide by zero gives all-ones quotient.
    function automatic logic [63:0] div_model(input logic sgn, input logic [31:0] a, input logic [31:0] b);
        logic [31:0] ma, mb, q, r;
        ma = sgn ? {1'b0, a[30:0]} : a;
        mb = sgn ? {1'b0, b[30:0]} : b;
        if (mb == 32'h0) begin
            q = 32'hFFFF_FFFF;
            r = a;
        end else begin
            q = ma / mb;
            r = ma % mb;
            if (sgn) begin
                q[31] = a[31] ^ b[31];
                r[31] = a[31];
            end
        end
        return {q, r};
    endfunction

    task automatic check_reset_outputs(input string tag);
        check({tag, "_req_ready"}, 64'(req_ready), 64'(0));
        check({tag, "_div_push"},  64'(div_push), 64'(0));
        check({tag, "_div_data"},  64'(div_data), 64'(0));
        check({tag, "_div_sign"},  64'(div_sign), 64'(0));
        check({tag, "_div_select"}, 64'(div_select), 64'(0));
        check({tag, "_rsp_valid"}, 64'(rsp_valid), 64'(0));
        check({tag, "_rsp_q"},     64'(rsp_quotient), 64'(0));
        check({tag, "_rsp_r"},     64'(rsp_remainder), 64'(0));
        check({tag, "_rsp_to"},    64'(rsp_timeout), 64'(0));
    endtask

    task automatic wait_ready();
        int n;
        n = 0;
        while (!req_ready && n < 50) begin
            @(negedge clk);
            n++;
        end
        check("req_ready_idle", 64'(req_ready), 64'(1));
    endtask

    // Drives one request from cycle 0 and plays the divider until the response handshake.
    task automatic run_txn(input logic sgn, input logic [31:0] a, input logic [31:0] b,
                           input int pull_lat, input int bp, input bit extra_pull, input bit no_pull,
                           input logic [31:0] eq, input logic [31:0] er, input logic eto);
        logic [63:0] res, ops;
        int          pull_at, rsp_at, n_push, n_valid;
        bit          prev_push, done, seen;
        rsp_t        first, got, e;
        res = div_model(sgn, a, b);
        ops = {a, b};
        wait_ready();
        req_valid = 1'b1;
        req_sign = sgn;
        req_dividend = a;
        req_divisor = b;
        rsp_ready = 1'b0;
        for (int i = 0; i < 8; i++) byte_q.push_back(ops[63 - 8*i -: 8]);
        exp_q.push_back('{q: eq, r: er, to: eto});
        pull_at = -1; rsp_at = -1; n_push = 0; n_valid = 0;
        prev_push = 1'b0; done = 1'b0; seen = 1'b0;
        for (int t = 1; t < 400 && !done; t++) begin
            @(negedge clk);
            req_valid = 1'b0;
            div_pull = 1'b0;
            div_dout = 8'h00;
            rsp_ready = 1'b0;
            if (div_push) begin
                check("push_single_cycle", 64'(prev_push), 64'(0));
                check("push_cycle", 64'(t), 64'((n_push + 1) * (GAP + 1)));
                if (byte_q.size() > 0) check("push_byte", 64'(div_data), 64'(byte_q.pop_front()));
                else check("push_extra", 64'(1), 64'(0));
                n_push++;
                if (n_push == 8) begin
                    pull_at = t + 1 + pull_lat;
                    rsp_at  = no_pull ? t + 1 + TO : pull_at + 8;
                end
            end
            prev_push = div_push;
            if (rsp_at < 0 || t < rsp_at)
                check("div_sign", 64'(div_sign), 64'(sgn));
            if (rsp_valid) begin
                got = '{q: rsp_quotient, r: rsp_remainder, to: rsp_timeout};
                if (!seen) begin
                    check("rsp_latency", 64'(t), 64'(rsp_at));
                    first = got;
                    seen = 1'b1;
                end else begin
                    check("rsp_stable", 64'(got[64:1]), 64'(first[64:1]));
                end
                check("req_ready_busy", 64'(req_ready), 64'(0));
                n_valid++;
                if (n_valid > bp) begin
                    rsp_ready = 1'b1;
                    if (exp_q.size() > 0) begin
                        e = exp_q.pop_front();
                        check("rsp_quotient", 64'(got.q), 64'(e.q));
                        check("rsp_remainder", 64'(got.r), 64'(e.r));
                        check("rsp_timeout", 64'(got.to), 64'(e.to));
                    end else begin
                        check("rsp_unexpected", 64'(1), 64'(0));
                    end
                    done = 1'b1;
                end else begin
                    req_valid = 1'b1;
                    req_dividend = 32'hDEAD_BEEF;
                end
            end
            // divider model
            if (no_pull && t == 5) begin
                div_pull = 1'b1;
                div_dout = 8'hAA;
            end else if (!no_pull && pull_at >= 0 && t == pull_at) begin
                div_pull = 1'b1;
                div_dout = res[7:0];
            end else if (!no_pull && pull_at >= 0 && t > pull_at && t <= pull_at + 7) begin
                div_dout = res[8*(t - pull_at) +: 8];
                if (extra_pull && t == pull_at + 2) div_pull = 1'b1;
            end
        end
        if (!done) check("rsp_wait_bound", 64'(0), 64'(1));
        @(negedge clk);
        rsp_ready = 1'b0;
        check("req_ready_after_rsp", 64'(req_ready), 64'(1));
        check("rsp_valid_after_rsp", 64'(rsp_valid), 64'(0));
        check("push_count", 64'(n_push), 64'(8));
        byte_q.delete();
    endtask

    initial begin
        logic [63:0] m;
        int          pushes;
        repeat (3) @(negedge clk);
        check_reset_outputs("reset");
        rst = 1'b0;
        @(negedge clk);
        check("req_ready_after_reset", 64'(req_ready), 64'(1));

        // 100 / 7 with literal expected result bytes
        run_txn(1'b0, 32'd100, 32'd7, 3, 0, 1'b0, 1'b0, 32'd14, 32'd2, 1'b0);
        // byte order, second pull during RECV ignored
        m = div_model(1'b0, 32'h1234_5678, 32'h0000_0100);
        run_txn(1'b0, 32'h1234_5678, 32'h0000_0100, 0, 0, 1'b1, 1'b0, m[63:32], m[31:0], 1'b0);
        // signed sign-magnitude: -100 / 7 -> -14 rem -2
        run_txn(1'b1, 32'h8000_0064, 32'h0000_0007, 2, 0, 1'b0, 1'b0, 32'h8000_000E, 32'h8000_0002, 1'b0);
        // backpressure for 20 cycles
        m = div_model(1'b0, 32'hFFFF_FFFF, 32'h0000_0010);
        run_txn(1'b0, 32'hFFFF_FFFF, 32'h0000_0010, 1, 20, 1'b0, 1'b0, m[63:32], m[31:0], 1'b0);
        // divide by zero forwarded unchanged
        run_txn(1'b0, 32'd1234, 32'd0, 4, 0, 1'b0, 1'b0, 32'hFFFF_FFFF, 32'd1234, 1'b0);

        // reset in the middle of SEND
        wait_ready();
        req_valid = 1'b1;
        req_dividend = 32'hA5A5_A5A5;
        req_divisor = 32'h5A5A_5A5A;
        req_sign = 1'b1;
        for (int t = 1; t < 7; t++) begin
            @(negedge clk);
            req_valid = 1'b0;
        end
        @(negedge clk);
        rst = 1'b1;
        @(negedge clk);
        check_reset_outputs("midsend_reset");
        rst = 1'b0;
        pushes = 0;
        @(negedge clk);
        check("req_ready_after_abort", 64'(req_ready), 64'(1));
        for (int t = 0; t < 20; t++) begin
            if (div_push || rsp_valid) pushes++;
            @(negedge clk);
        end
        check("no_activity_after_abort", 64'(pushes), 64'(0));
        m = div_model(1'b0, 32'd999, 32'd10);
        run_txn(1'b0, 32'd999, 32'd10, 0, 0, 1'b0, 1'b0, m[63:32], m[31:0], 1'b0);

`ifdef DIV_HOST_BRIDGE_TIMEOUT_EN
        // no div_pull: timeout with zero result, stray pull during SEND ignored
        run_txn(1'b0, 32'd50, 32'd5, 0, 0, 1'b0, 1'b1, 32'd0, 32'd0, 1'b1);
        // pull in the expiry cycle wins
        run_txn(1'b0, 32'd50, 32'd5, TO - 1, 0, 1'b0, 1'b0, 32'd10, 32'd0, 1'b0);
`endif

        $display("[TB] %0d tests run, %0d failed", n_tests, n_fail);
        $finish;
    end
endmodule

// File: doc/div_host_bridge.md
# div_host_bridge

Host-side bridge for the byte-serial integer divider top. It accepts one division request as parallel 32-bit operands and serialises the eight operand bytes onto the divider's push/data input port. It then waits for the divider's result burst, deserialises eight result bytes into a 32-bit quotient and a 32-bit remainder, and returns them through a valid/ready response port. It replaces bench-level byte banging, letting a CPU or DMA front end drive the divider.

## Interface
Parameters:
- GAP_CYCLES, 1: setup cycles (div_push low, data stable) before each push strobe; legal range 1..15.
- TIMEOUT_CYCLES, 255: cycles to wait for div_pull before giving up; used only with the macro in Configuration; legal range 1..65535.

Ports:
- clk  in  1  the single clock domain.
- rst  in  1  reset; synchronous and active-high.
- req_valid  in  1  request present.
- req_ready  out  1  bridge can accept a request.
- req_sign  in  1  0 = unsigned, 1 = signed (sign-magnitude, bit 31 = sign).
- req_dividend  in  32  dividend.
- req_divisor  in  32  divisor.
- div_push  out  1  push strobe to the divider.
- div_data  out  8  byte to the divider.
- div_sign  out  1  sign mode to the divider.
- div_select  out  1  unit select; tied 0 (integer divide).
- div_pull  in  1  first-result-byte marker from the divider.
- div_dout  in  8  result byte from the divider.
- rsp_valid  out  1  result available.
- rsp_ready  in  1  consumer takes the result.
- rsp_quotient  out  32  quotient.
- rsp_remainder  out  32  remainder.
- rsp_timeout  out  1  result invalid because no div_pull arrived.

## Operation
- States:
  - IDLE: req_ready=1. req_valid&&req_ready latches both operands and the sign bit, then goes to SEND.
  - SEND: walks byte index k=0..7 in this order: dividend[31:24], [23:16], [15:8], [7:0], then divisor[31:24], [23:16], [15:8], [7:0].
    - For each byte: GAP_CYCLES cycles with div_push=0 and div_data holding the byte, then one cycle with div_push=1 and div_data unchanged.
    - After the eighth push, go to WAIT.
  - WAIT: wait for div_pull=1. In that cycle, capture div_dout as result byte 0 and go to RECV.
  - RECV: capture div_dout on each of the next 7 cycles as bytes 1..7, then go to DONE.
  - DONE: rsp_valid=1 and outputs stable until rsp_valid&&rsp_ready, then go to IDLE.
- Result assembly: byte i goes to {quotient,remainder}[8i+7:8i].
  - Bytes 0..3 form remainder, LSB first.
  - Bytes 4..7 form quotient, LSB first.
- Both the shift register and the counter are sized exactly for 8 bytes.
- div_sign holds the latched req_sign from SEND through RECV. It is 0 in IDLE.
- The bridge performs no arithmetic and no sign correction. A divisor of 0 is forwarded unchanged, and the bridge returns whatever the divider emits.
- div_pull is ignored in IDLE, SEND, RECV and DONE. A second div_pull during RECV does not restart capture.
- A new request is accepted only in IDLE.

## Timing
- rst high: state goes to IDLE; byte counter, shift register and timeout counter clear.
  - Reset values: req_ready=0, div_push=0, div_data=0, div_sign=0, div_select=0, rsp_valid=0, rsp_quotient=0, rsp_remainder=0, rsp_timeout=0.
  - req_ready rises on the first cycle after rst falls.
- rst asserted mid-transaction (any state) aborts it. No partial push or response follows.
- Latency, with acceptance at cycle 0:
  - SEND starts at cycle 1.
  - Push of byte k occurs at cycle (k+1)(GAP_CYCLES+1). With GAP_CYCLES=1 the pushes fall at cycles 2, 4, …, 16.
  - WAIT starts on the cycle after the last push.
  - If div_pull is seen at cycle P, rsp_valid rises at P+8.
- div_push is never high on two consecutive cycles.
- rsp_valid with rsp_ready held high: the response lasts exactly one cycle, and req_ready is high on the next cycle.

## Configuration
- DIV_HOST_BRIDGE_TIMEOUT_EN defined:
  - A 16-bit counter runs in WAIT.
  - If TIMEOUT_CYCLES cycles pass without div_pull, go to DONE with rsp_timeout=1 and quotient=remainder=0.
  - div_pull arriving in the same cycle as expiry wins, i.e. a normal capture.
- Not defined: no counter; WAIT persists indefinitely; rsp_timeout is constant 0.

## Test plan
- Unsigned 100/7, GAP_CYCLES=1: divider model emits div_pull plus bytes 02 00 00 00 0E 00 00 00 → rsp_quotient=14, rsp_remainder=2, rsp_timeout=0, rsp_valid at P+8.
- Byte order: dividend 0x12345678, divisor 0x00000100 → pushes at cycles 2..16 carry 12 34 56 78 00 00 01 00; div_sign=0; div_push is a single-cycle pulse each time.
- Signed mode: req_sign=1, dividend 0x80000064, divisor 0x00000007 → div_sign=1 from cycle 1 until DONE; the returned bytes are reassembled verbatim.
- Backpressure: rsp_ready low for 20 cycles → rsp_valid and the result are stable throughout; req_valid is not accepted until the handshake completes.
- Reset at cycle 7 (mid-SEND): no further div_push, all outputs return to their reset values, and a following request completes correctly.
- Timeout, macro defined, TIMEOUT_CYCLES=10, no div_pull → rsp_valid with rsp_timeout=1 at WAIT entry+10. A stray div_pull during SEND is ignored.
